// File: rtl/axis_pkt_checker_if.sv
// AXI-Stream bundle between the PANIC rx output and the packet checker.
interface axis_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pkt_checker.sv
// AXI-Stream packet sink: parses a UDP/IPv4 header beat, checks sequence-numbered
// payload beats, drives LFSR backpressure and keeps packet/byte/error statistics.
module axis_pkt_checker #(
  parameter int          DATA_WIDTH = 512,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter bit          STRICT_SEQ = 1'b1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  axis_if.slave       s_axis,
  input  logic [1:0]  ready_mode_i,
  input  logic [6:0]  ready_thresh_i,
  input  logic        stat_clear_i,
  output logic        pkt_done_o,
  output logic        pkt_ok_o,
  output logic [4:0]  pkt_err_o,
  output logic [7:0]  pkt_flow_id_o,
  output logic [15:0] pkt_words_o,
  output logic [31:0] stat_pkts_o,
  output logic [63:0] stat_bytes_o,
  output logic [31:0] stat_errs_o,
  output logic [4:0]  err_sticky_o
);

  localparam int CNT_W = $clog2(KEEP_WIDTH + 1);

  typedef enum logic [0:0] {S_HDR, S_BODY} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        tready_q, tready_d;
  logic [10:0] exp_words_q, exp_words_d;
  logic [7:0]  flow_q, flow_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [63:0] base_q, base_d;
  logic [4:0]  err_acc_q, err_acc_d;
  logic [63:0] exp_seq_q, exp_seq_d;
  logic        pkt_done_q, pkt_done_d;
  logic        pkt_ok_q, pkt_ok_d;
  logic [4:0]  pkt_err_q, pkt_err_d;
  logic [7:0]  pkt_flow_id_q, pkt_flow_id_d;
  logic [15:0] pkt_words_q, pkt_words_d;
  logic [31:0] stat_pkts_q, stat_pkts_d;
  logic [63:0] stat_bytes_q, stat_bytes_d;
  logic [31:0] stat_errs_q, stat_errs_d;
  logic [4:0]  err_sticky_q, err_sticky_d;

  logic             accept;
  logic             keep_full;
  logic [63:0]      word;
  logic [15:0]      hdr_len;
  logic [16:0]      len_sum;
  logic [10:0]      hdr_words;
  logic [CNT_W-1:0] keep_cnt;
  logic [4:0]       beat_err;
  logic             finish;
  logic [15:0]      words_fin;
  logic [7:0]       flow_fin;
  logic             unused_tdata;

  assign accept    = s_axis.tvalid && tready_q;
  assign keep_full = &s_axis.tkeep;
  assign word      = s_axis.tdata[63:0];
  assign hdr_len   = {s_axis.tdata[135:128], s_axis.tdata[143:136]};
  assign len_sum   = {1'b0, hdr_len} + 17'd14;
  assign hdr_words = len_sum[16:6];
  assign unused_tdata = ^s_axis.tdata;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_cnt = keep_cnt + CNT_W'(s_axis.tkeep[i]);
    end
  end

  // Galois LFSR, x^16+x^14+x^13+x^11; free-running so backpressure is traffic independent.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    case (ready_mode_i)
      2'd1:    tready_d = (lfsr_q[6:0] < ready_thresh_i);
      2'd2:    tready_d = 1'b0;
      default: tready_d = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    exp_words_d   = exp_words_q;
    flow_d        = flow_q;
    beat_cnt_d    = beat_cnt_q;
    base_d        = base_q;
    err_acc_d     = err_acc_q;
    exp_seq_d     = exp_seq_q;
    pkt_done_d    = 1'b0;
    pkt_ok_d      = pkt_ok_q;
    pkt_err_d     = pkt_err_q;
    pkt_flow_id_d = pkt_flow_id_q;
    pkt_words_d   = pkt_words_q;
    beat_err      = '0;
    finish        = 1'b0;
    words_fin     = beat_cnt_q;
    flow_fin      = flow_q;

    if (accept) begin
      case (state_q)
        S_HDR: begin
          if (len_sum[5:0] != 6'd0 || hdr_words == 11'd0) beat_err[4] = 1'b1;
          if (!keep_full) beat_err[1] = 1'b1;
          exp_words_d = hdr_words;
          flow_d      = s_axis.tdata[287:280];
          beat_cnt_d  = 16'd1;
          if (s_axis.tlast) begin
            if (hdr_words != 11'd1) beat_err[0] = 1'b1;
            finish    = 1'b1;
            words_fin = 16'd1;
            flow_fin  = s_axis.tdata[287:280];
          end else begin
            state_d = S_BODY;
          end
          err_acc_d = beat_err;
        end
        S_BODY: begin
          // beat_cnt_q counts the header, so it equals the payload index k here.
          if (beat_cnt_q == 16'd1) begin
            base_d = word - 64'd1;
            if (STRICT_SEQ && (word - 64'd1) != exp_seq_q) beat_err[3] = 1'b1;
          end else if (word != base_q + {48'h0, beat_cnt_q}) begin
            beat_err[2] = 1'b1;
          end
          if (!keep_full) beat_err[1] = 1'b1;
          if (beat_cnt_q >= {5'h0, exp_words_q}) beat_err[0] = 1'b1;
          if (s_axis.tlast && ({1'b0, beat_cnt_q} + 17'd1) < {6'h0, exp_words_q})
            beat_err[0] = 1'b1;
          beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
          err_acc_d  = err_acc_q | beat_err;
          if (s_axis.tlast) begin
            finish    = 1'b1;
            words_fin = beat_cnt_d;
            state_d   = S_HDR;
          end
        end
        default: state_d = S_HDR;
      endcase
    end

    if (finish) begin
      pkt_done_d    = 1'b1;
      pkt_ok_d      = (err_acc_d == 5'd0);
      pkt_err_d     = err_acc_d;
      pkt_flow_id_d = flow_fin;
      pkt_words_d   = words_fin;
      if (STRICT_SEQ) exp_seq_d = exp_seq_q + 64'd1;
    end
  end

  // A clear in the same cycle as an increment keeps just that increment.
  always_comb begin
    stat_pkts_d  = (stat_clear_i ? 32'd0 : stat_pkts_q) + {31'd0, finish};
    stat_errs_d  = (stat_clear_i ? 32'd0 : stat_errs_q) + {31'd0, finish && (err_acc_d != 5'd0)};
    stat_bytes_d = (stat_clear_i ? 64'd0 : stat_bytes_q) + (accept ? 64'(keep_cnt) : 64'd0);
    err_sticky_d = (stat_clear_i ? 5'd0 : err_sticky_q) | (finish ? err_acc_d : 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HDR;
      lfsr_q        <= LFSR_SEED;
      tready_q      <= 1'b0;
      exp_words_q   <= '0;
      flow_q        <= '0;
      beat_cnt_q    <= '0;
      base_q        <= '0;
      err_acc_q     <= '0;
      exp_seq_q     <= 64'd1;
      pkt_done_q    <= 1'b0;
      pkt_ok_q      <= 1'b0;
      pkt_err_q     <= '0;
      pkt_flow_id_q <= '0;
      pkt_words_q   <= '0;
      stat_pkts_q   <= '0;
      stat_bytes_q  <= '0;
      stat_errs_q   <= '0;
      err_sticky_q  <= '0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      tready_q      <= tready_d;
      exp_words_q   <= exp_words_d;
      flow_q        <= flow_d;
      beat_cnt_q    <= beat_cnt_d;
      base_q        <= base_d;
      err_acc_q     <= err_acc_d;
      exp_seq_q     <= exp_seq_d;
      pkt_done_q    <= pkt_done_d;
      pkt_ok_q      <= pkt_ok_d;
      pkt_err_q     <= pkt_err_d;
      pkt_flow_id_q <= pkt_flow_id_d;
      pkt_words_q   <= pkt_words_d;
      stat_pkts_q   <= stat_pkts_d;
      stat_bytes_q  <= stat_bytes_d;
      stat_errs_q   <= stat_errs_d;
      err_sticky_q  <= err_sticky_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign pkt_done_o    = pkt_done_q;
  assign pkt_ok_o      = pkt_ok_q;
  assign pkt_err_o     = pkt_err_q;
  assign pkt_flow_id_o = pkt_flow_id_q;
  assign pkt_words_o   = pkt_words_q;
  assign stat_pkts_o   = stat_pkts_q;
  assign stat_bytes_o  = stat_bytes_q;
  assign stat_errs_o   = stat_errs_q;
  assign err_sticky_o  = err_sticky_q;

endmodule
